eaglesong_nonce_sequencer: RTL
==============================

Name: eaglesong_nonce_sequencer

Overview:
Upstream job controller for eaglesong_digest_top. It accepts a mining job (header, start nonce, nonce count, target) and drives the digest block once per nonce with input_val = {header, nonce}. It checks each 256-bit digest against the target and stops on the first hit, on exhaustion of the nonce range, or on a watchdog timeout. The result is held behind a valid/ack handshake.

Parameters:
NONCE_W, 64, nonce width; header width is 256-NONCE_W
TIMEOUT_CYCLES, 1023, maximum cycles in WAIT per digest before the timeout error

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
job_start  in  1  one-cycle pulse; accepted only when job_ready=1
job_header  in  256-NONCE_W  header bits, latched on accept
job_nonce_start  in  NONCE_W  first nonce, latched on accept
job_nonce_count  in  NONCE_W  number of nonces to try, latched on accept
job_target  in  256  hit when digest < target (unsigned), latched on accept
abort  in  1  cancel current job
job_ready  out  1  high in IDLE only
busy  out  1  high in LOAD/START/WAIT/CHECK
dg_input_val  out  256  to digest input_val: {header_q, nonce_q}
dg_input_length_bytes  out  7  constant 7'd32
dg_start_eval  out  1  registered one-cycle pulse to digest start_eval
dg_output_val  in  256  digest output_val
dg_eval_output_ready  in  1  digest eval_output_ready (level)
result_valid  out  1  held until result_ack
result_status  out  2  0=FOUND, 1=EXHAUSTED, 2=TIMEOUT
result_nonce  out  NONCE_W  nonce of hit (FOUND) or last nonce tried
result_digest  out  256  digest of result_nonce; 0 for TIMEOUT or count=0
result_ack  in  1  consumer accepts result

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, job_ready=1, busy=0, dg_start_eval=0, result_valid=0, result_status=0, result_nonce=0, result_digest=0, all latched job registers=0, timeout counter=0.
- IDLE: job_start=1 and abort=0 -> latch all job inputs -> LOAD. If abort=1 in the same cycle, abort wins and the state stays IDLE.
- LOAD: remaining_q = count. If remaining_q==0 -> DONE with EXHAUSTED, result_nonce=nonce_start, result_digest=0, no dg_start_eval issued. Else -> START.
- START: dg_start_eval=1 for exactly this cycle. dg_input_val must be stable from START until leaving WAIT. Clear the timeout counter. -> WAIT.
- WAIT: dg_eval_output_ready is sampled only in this state; the stale ready level visible during START is ignored by construction. On ready=1: register dg_output_val into digest_q -> CHECK. Each cycle without ready, increment the timeout counter. When the counter reaches TIMEOUT_CYCLES -> DONE with TIMEOUT, result_nonce=nonce_q, result_digest=0.
- CHECK (1 cycle): hit = digest_q < target_q.
  - Hit -> DONE with FOUND, result_nonce=nonce_q, result_digest=digest_q.
  - Else if remaining_q==1 -> DONE with EXHAUSTED, result_nonce=nonce_q, result_digest=digest_q.
  - Else nonce_q = nonce_q+1 (wraps modulo 2^NONCE_W, no flag), remaining_q = remaining_q-1 -> START.
  - A hit on the last nonce reports FOUND, not EXHAUSTED.
- DONE: result_valid=1 and all result_* held stable. result_ack=1 -> result_valid=0 next cycle -> IDLE. job_start is ignored in DONE.
- abort=1 in LOAD/START/WAIT/CHECK -> IDLE next cycle, with no result_valid and dg_start_eval=0. Any in-flight digest is discarded; the next job's start_eval clears the digest's ready. abort in DONE is ignored; ack is still required.
- job_start while busy or in DONE: ignored, no effect on the latched job.
- Per-nonce cost: 1 (START) + digest latency + 1 (CHECK) cycles. Sustained throughput is one digest in flight at a time.
- Reset mid-job returns to the reset values immediately, including dg_start_eval=0.

Decomposition:
- Shared package eaglesong_pkg holds:
  - a state enum {IDLE, LOAD, START, WAIT, CHECK, DONE};
  - result status codes STATUS_FOUND, STATUS_EXHAUSTED, STATUS_TIMEOUT;
  - DIGEST_W=256;
  - LEN_BYTES_FULL=7'd32.
- One sub-module: eaglesong_target_compare, a combinational 256-bit unsigned less-than with output hit. It is instantiated on digest_q/target_q and reused by later difficulty-filter stages.

Test Plan:
- Target all-ones, count=4, nonce_start=0x10, digest stub returns any value below all-ones after 40 cycles -> exactly one dg_start_eval pulse; FOUND, result_nonce=0x10, result_digest equals the stub value; dg_input_val[63:0]=0x10.
- Target=0, count=3, nonce_start=0xFFFF_FFFF_FFFF_FFFE -> three start pulses with nonces ...FE, ...FF, 0x0 (wrap); EXHAUSTED, result_nonce=0x0.
- count=0 -> no dg_start_eval; EXHAUSTED two cycles after accept, result_nonce=nonce_start, result_digest=0.
- Stub never asserts ready, TIMEOUT_CYCLES=15 -> TIMEOUT with result_nonce=nonce_start; result_valid held for 5 cycles until result_ack, then job_ready=1.
- Abort asserted during WAIT of nonce 2 of 5 -> IDLE next cycle, no result_valid. A new job then accepted while the stub's stale ready is still high -> the new job's result uses the new digest, not the stale one.
- job_start+abort in the same IDLE cycle -> stays IDLE. job_start pulse during WAIT -> ignored; latched header unchanged in dg_input_val.

Source files
------------

// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the eaglesong job sequencer and its helpers.
package eaglesong_pkg;

   localparam int         DIGEST_W       = 256;
   localparam logic [6:0] LEN_BYTES_FULL = 7'd32;

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, CHECK, DONE} state_e;

   localparam logic [1:0] STATUS_FOUND     = 2'd0;
   localparam logic [1:0] STATUS_EXHAUSTED = 2'd1;
   localparam logic [1:0] STATUS_TIMEOUT   = 2'd2;

endpackage

// File: rtl/eaglesong_target_compare.sv
// Combinational unsigned digest-versus-target test; hit when digest is below target.
module eaglesong_target_compare
   import eaglesong_pkg::*;
(
   input  logic [DIGEST_W-1:0] digest_i,
   input  logic [DIGEST_W-1:0] target_i,
   output logic                hit_o
);

   assign hit_o = digest_i < target_i;

endmodule

// File: rtl/eaglesong_nonce_sequencer.sv
// Walks a nonce range through the digest block, one digest in flight at a time,
// and reports the first hit, range exhaustion, or a per-digest watchdog timeout.
module eaglesong_nonce_sequencer
   import eaglesong_pkg::*;
#(
   parameter int NONCE_W        = 64,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         job_start,
   input  logic [DIGEST_W-NONCE_W-1:0]  job_header,
   input  logic [NONCE_W-1:0]           job_nonce_start,
   input  logic [NONCE_W-1:0]           job_nonce_count,
   input  logic [DIGEST_W-1:0]          job_target,
   input  logic                         abort,
   output logic                         job_ready,
   output logic                         busy,
   output logic [DIGEST_W-1:0]          dg_input_val,
   output logic [6:0]                   dg_input_length_bytes,
   output logic                         dg_start_eval,
   input  logic [DIGEST_W-1:0]          dg_output_val,
   input  logic                         dg_eval_output_ready,
   output logic                         result_valid,
   output logic [1:0]                   result_status,
   output logic [NONCE_W-1:0]           result_nonce,
   output logic [DIGEST_W-1:0]          result_digest,
   input  logic                         result_ack
);

   localparam int HDR_W = DIGEST_W - NONCE_W;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   state_e               state_q, state_d;
   logic [HDR_W-1:0]     header_q, header_d;
   logic [NONCE_W-1:0]   nonce_q, nonce_d;
   logic [NONCE_W-1:0]   count_q, count_d;
   logic [NONCE_W-1:0]   remaining_q, remaining_d;
   logic [DIGEST_W-1:0]  target_q, target_d;
   logic [DIGEST_W-1:0]  digest_q, digest_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 start_q, start_d;
   logic [1:0]           rstat_q, rstat_d;
   logic [NONCE_W-1:0]   rnonce_q, rnonce_d;
   logic [DIGEST_W-1:0]  rdig_q, rdig_d;
   logic                 hit;

   eaglesong_target_compare u_cmp (
      .digest_i (digest_q),
      .target_i (target_q),
      .hit_o    (hit)
   );

   assign job_ready             = (state_q == IDLE);
   assign busy                  = (state_q inside {LOAD, START, WAIT, CHECK});
   assign result_valid          = (state_q == DONE);
   assign dg_input_val          = {header_q, nonce_q};
   assign dg_input_length_bytes = LEN_BYTES_FULL;
   assign dg_start_eval         = start_q;
   assign result_status         = rstat_q;
   assign result_nonce          = rnonce_q;
   assign result_digest         = rdig_q;

   always_comb begin
      state_d     = state_q;
      header_d    = header_q;
      nonce_d     = nonce_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      target_d    = target_q;
      digest_d    = digest_q;
      tmo_d       = tmo_q;
      start_d     = 1'b0;
      rstat_d     = rstat_q;
      rnonce_d    = rnonce_q;
      rdig_d      = rdig_q;
      case (state_q)
         IDLE: if (job_start && !abort) begin
            header_d = job_header;
            nonce_d  = job_nonce_start;
            count_d  = job_nonce_count;
            target_d = job_target;
            state_d  = LOAD;
         end
         LOAD: begin
            remaining_d = count_q;
            if (count_q == '0) begin
               state_d  = DONE;
               rstat_d  = STATUS_EXHAUSTED;
               rnonce_d = nonce_q;
               rdig_d   = '0;
            end else begin
               state_d = START;
               start_d = 1'b1;
            end
         end
         START: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         // Ready is only looked at here; START's stale level never reaches CHECK.
         WAIT: if (dg_eval_output_ready) begin
            digest_d = dg_output_val;
            state_d  = CHECK;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_q == TMO_LAST) begin
               state_d  = DONE;
               rstat_d  = STATUS_TIMEOUT;
               rnonce_d = nonce_q;
               rdig_d   = '0;
            end
         end
         CHECK: begin
            if (hit || remaining_q == NONCE_W'(1)) begin
               state_d  = DONE;
               rstat_d  = hit ? STATUS_FOUND : STATUS_EXHAUSTED;
               rnonce_d = nonce_q;
               rdig_d   = digest_q;
            end else begin
               nonce_d     = nonce_q + NONCE_W'(1);
               remaining_d = remaining_q - NONCE_W'(1);
               state_d     = START;
               start_d     = 1'b1;
            end
         end
         DONE: if (result_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && busy) begin
         state_d  = IDLE;
         start_d  = 1'b0;
         rstat_d  = rstat_q;
         rnonce_d = rnonce_q;
         rdig_d   = rdig_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         header_q    <= '0;
         nonce_q     <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         target_q    <= '0;
         digest_q    <= '0;
         tmo_q       <= '0;
         start_q     <= 1'b0;
         rstat_q     <= '0;
         rnonce_q    <= '0;
         rdig_q      <= '0;
      end else begin
         state_q     <= state_d;
         header_q    <= header_d;
         nonce_q     <= nonce_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         target_q    <= target_d;
         digest_q    <= digest_d;
         tmo_q       <= tmo_d;
         start_q     <= start_d;
         rstat_q     <= rstat_d;
         rnonce_q    <= rnonce_d;
         rdig_q      <= rdig_d;
      end
   end

endmodule
